// File: rtl/stv_hsiao_check_pkg.sv
// stv_hsiao_check_pkg: Hsiao column construction and syndrome helpers shared by the SECDED blocks
package stv_hsiao_check_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SEC,
    ERR_DED
  } err_t;

  // Column m of H: the m-th odd-weight (>=3) PWIDTH-bit pattern, lightest weights first, ascending value
  function automatic logic [31:0] stv_hsiao_col(input int dwidth, input int pwidth, input int m);
    int n;
    n = 0;
    if (m >= dwidth) return '0;
    for (int w = 3; w <= pwidth; w += 2)
      for (int v = 1; v < (1 << pwidth); v++)
        if ($countones(v) == w) begin
          if (n == m) return 32'(v);
          n++;
        end
    return '0;
  endfunction

  function automatic logic stv_hsiao(input int dwidth, input int pwidth, input int m, input int p);
    logic [31:0] col;
    col = stv_hsiao_col(dwidth, pwidth, m);
    return col[p];
  endfunction

  // Row p of H: which data bits feed parity bit p
  function automatic logic [63:0] stv_hsiao_row(input int dwidth, input int pwidth, input int p);
    logic [63:0] row;
    row = '0;
    for (int m = 0; m < dwidth && m < 64; m++) row[m] = stv_hsiao(dwidth, pwidth, m, p);
    return row;
  endfunction

  function automatic logic stv_hsiao_syndrome_match(input int dwidth, input int pwidth, input int m,
                                                    input logic [31:0] syn);
    logic [31:0] mask;
    mask = (32'(1) << pwidth) - 32'(1);
    return (m < dwidth) && ((syn & mask) == stv_hsiao_col(dwidth, pwidth, m));
  endfunction

endpackage

// File: rtl/stv_hsiao_check_parity.sv
// stv_hsiao_check_parity: combinational Hsiao parity generator over one message word
module stv_hsiao_check_parity
  import stv_hsiao_check_pkg::*;
#(
  parameter type DTYPE  = logic [3:0],
  parameter int  PWIDTH = 4
) (
  input  DTYPE              data,
  output logic [PWIDTH-1:0] parity
);

  localparam int DWIDTH = $bits(DTYPE);

  logic [DWIDTH-1:0] d;

  assign d = data;

  for (genvar p = 0; p < PWIDTH; p++) begin : g_row
    localparam logic [63:0] ROW = stv_hsiao_row(DWIDTH, PWIDTH, p);
    assign parity[p] = ^(d & ROW[DWIDTH-1:0]);
  end

endmodule

// File: rtl/stv_hsiao_check.sv
// stv_hsiao_check: two-stage pipelined Hsiao SECDED decoder with saturating error counters
module stv_hsiao_check
  import stv_hsiao_check_pkg::*;
#(
  parameter type DTYPE       = logic [3:0],
  parameter int  PWIDTH      = 4,
  parameter int  COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  DTYPE                   in_data,
  input  logic [PWIDTH-1:0]      in_parity,
  output logic                   out_valid,
  input  logic                   out_ready,
  output DTYPE                   out_data,
  output logic                   out_sec,
  output logic                   out_ded,
  output logic [COUNT_WIDTH-1:0] sec_count,
  output logic [COUNT_WIDTH-1:0] ded_count,
  input  logic                   count_clear
);

  localparam int DWIDTH = $bits(DTYPE);

  if (PWIDTH < 1 + $clog2(DWIDTH + PWIDTH)) begin : g_bad_pwidth
    $fatal(1, "stv_hsiao_check: PWIDTH too small for DWIDTH");
  end

  logic              s1_valid;
  logic              s1_adv;
  logic              s2_adv;
  logic              out_hs;
  logic [DWIDTH-1:0] s1_data;
  logic [DWIDTH-1:0] flip;
  logic [PWIDTH-1:0] s1_syn;
  logic [PWIDTH-1:0] calc;
  err_t              err;

  stv_hsiao_check_parity #(.DTYPE(DTYPE), .PWIDTH(PWIDTH)) u_parity (
    .data  (in_data),
    .parity(calc)
  );

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid && out_ready;

  for (genvar m = 0; m < DWIDTH; m++) begin : g_col
    assign flip[m] = stv_hsiao_syndrome_match(DWIDTH, PWIDTH, m, 32'(s1_syn));
  end

  // Classify the syndrome: a data-column or one-hot parity hit is correctable, any other nonzero is not
  always_comb err = (s1_syn == '0) ? ERR_NONE : (|flip || $onehot(s1_syn)) ? ERR_SEC : ERR_DED;

  // Stage 1: capture the received word and its syndrome
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (s1_adv) s1_valid <= in_valid;
    if (in_valid && s1_adv) begin
      s1_data <= in_data;
      s1_syn  <= calc ^ in_parity;
    end
  end

  // Stage 2: corrected data and flags, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sec   <= 1'b0;
      out_ded   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_data ^ flip;
        out_sec  <= err == ERR_SEC;
        out_ded  <= err == ERR_DED;
      end
    end
  end

  // Saturating counters of delivered results; clear wins over a coincident event
  always_ff @(posedge clk) begin
    if (rst || count_clear) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (out_hs) begin
      if (out_sec && !(&sec_count)) sec_count <= sec_count + 1'b1;
      if (out_ded && !(&ded_count)) ded_count <= ded_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_stv_hsiao_check.sv
// tb_stv_hsiao_check: directed table-driven bench for the Hsiao SECDED decoder
module tb_stv_hsiao_check;

  typedef struct {
    logic [7:0] data;
    logic [4:0] par;
    logic [7:0] exp_data;
    logic       exp_sec;
    logic       exp_ded;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [4:0] in_parity = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_sec;
  logic       out_ded;
  logic [1:0] sec_count;
  logic [1:0] ded_count;
  logic       count_clear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[11];

  stv_hsiao_check #(.DTYPE(logic [7:0]), .PWIDTH(5), .COUNT_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_parity  (in_parity),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sec    (out_sec),
    .out_ded    (out_ded),
    .sec_count  (sec_count),
    .ded_count  (ded_count),
    .count_clear(count_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [4:0] p);
    int n;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_accept", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
  endtask

  initial begin
    int n;
    int k;
    logic [1:0] xsc;
    logic [1:0] xdc;
    logic [7:0] got[3];
    // H columns for 8 data bits: 07,0B,0D,0E,13,15,16,19; parity(A5)=06, parity(FF)=06
    vecs[0]  = '{8'hA5, 5'h06, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{8'hAD, 5'h06, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{8'hA5, 5'h02, 8'hA5, 1'b1, 1'b0};
    vecs[3]  = '{8'h24, 5'h06, 8'h24, 1'b0, 1'b1};
    vecs[4]  = '{8'hA5, 5'h16, 8'hA5, 1'b1, 1'b0};
    vecs[5]  = '{8'h25, 5'h06, 8'hA5, 1'b1, 1'b0};
    vecs[6]  = '{8'h00, 5'h00, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{8'h00, 5'h07, 8'h01, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 5'h1F, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{8'h00, 5'h1A, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{8'hFF, 5'h06, 8'hFF, 1'b0, 1'b0};
    xsc = '0;
    xdc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sec", 32'(out_sec), 0);
    chk("rst_out_ded", 32'(out_ded), 0);
    chk("rst_sec_count", 32'(sec_count), 0);
    chk("rst_ded_count", 32'(ded_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    foreach (vecs[i]) begin
      push(vecs[i].data, vecs[i].par);
      wait_out(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 2);
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_sec", i), 32'(out_sec), 32'(vecs[i].exp_sec));
      chk($sformatf("v%0d_ded", i), 32'(out_ded), 32'(vecs[i].exp_ded));
      @(posedge clk);
      if (vecs[i].exp_sec && xsc != 2'd3) xsc++;
      if (vecs[i].exp_ded && xdc != 2'd3) xdc++;
      @(negedge clk);
      chk($sformatf("v%0d_sec_count", i), 32'(sec_count), 32'(xsc));
      chk($sformatf("v%0d_ded_count", i), 32'(ded_count), 32'(xdc));
    end
    // Backpressure: two words fill the pipe, the third is refused until release
    @(negedge clk);
    out_ready = 1'b0;
    push(8'h01, 5'h07);
    push(8'h02, 5'h0B);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h03;
    in_parity = 5'h0C;
    chk("bp_in_ready_full", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_out_data", 32'(out_data), 32'h01);
    @(negedge clk);
    chk("bp_in_ready_still", 32'(in_ready), 0);
    chk("bp_hold_data", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    k = 0;
    if (out_valid) begin
      got[k] = out_data;
      k++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (k < 3 && n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        got[k] = out_data;
        k++;
      end
    end
    chk("bp_count", 32'(k), 3);
    chk("bp_first", 32'(got[0]), 32'h01);
    chk("bp_second", 32'(got[1]), 32'h02);
    chk("bp_third", 32'(got[2]), 32'h03);
    // Saturation of sec_count after a clear
    @(negedge clk);
    count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    chk("clr_sec_count", 32'(sec_count), 0);
    chk("clr_ded_count", 32'(ded_count), 0);
    repeat (5) push(8'hAD, 5'h06);
    repeat (6) @(negedge clk);
    chk("sat_sec_count", 32'(sec_count), 3);
    chk("sat_ded_count", 32'(ded_count), 0);
    // Clear coincident with an SEC handshake drops the event
    push(8'hAD, 5'h06);
    wait_out(n);
    chk("coinc_out_sec", 32'(out_sec), 1);
    count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    chk("coinc_sec_count", 32'(sec_count), 0);
    push(8'hAD, 5'h06);
    wait_out(n);
    @(posedge clk);
    @(negedge clk);
    chk("resume_sec_count", 32'(sec_count), 1);
    // Reset mid-stream discards in-flight words
    out_ready = 1'b0;
    push(8'hA5, 5'h06);
    push(8'hAD, 5'h06);
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_sec_count", 32'(sec_count), 0);
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    chk("mid_rst_no_emit", 32'(k), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
